// File: rtl/boot_loader.sv
// boot_loader: framed byte-stream loader for the RISC_SPM program SRAM.
// Frames are ADDR, LEN, LEN data bytes, CKSUM; a LEN of 0 ends the load.
// Data bytes are written as they arrive, and the core is released only
// after a clean end record.
module boot_loader #(
  parameter int word_size = 8,
  parameter int addr_size = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [word_size-1:0] in_data,
  output logic                 in_ready,
  output logic                 mem_we,
  output logic [addr_size-1:0] mem_addr,
  output logic [word_size-1:0] mem_data,
  output logic                 cpu_run,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

  typedef enum logic [2:0] {
    S_ADDR,
    S_LEN,
    S_DATA,
    S_CKSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t               state_q, state_d;
  logic [addr_size-1:0] ptr_q, ptr_d;
  logic [word_size-1:0] acc_q, acc_d;
  logic [word_size-1:0] cnt_q, cnt_d;
  logic                 mem_we_q, mem_we_d;
  logic [addr_size-1:0] mem_addr_q, mem_addr_d;
  logic [word_size-1:0] mem_data_q, mem_data_d;
  logic [word_size-1:0] acc_sum;
  logic                 xfer;

  // Status outputs are pure decodes of the current state.
  assign in_ready = (state_q != S_DONE) && (state_q != S_ERR);
  assign busy     = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CKSUM);
  assign done     = (state_q == S_DONE);
  assign error    = (state_q == S_ERR);
  assign cpu_run  = done;
  assign mem_we   = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_data = mem_data_q;

  assign xfer    = in_valid && in_ready;
  assign acc_sum = acc_q + in_data;

  // Next-state logic: frame parsing, running checksum and write issue.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d    = state_q;
    ptr_d      = ptr_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    mem_we_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    if (xfer) begin
      unique case (state_q)
        S_ADDR: begin
          ptr_d   = addr_size'(in_data);
          acc_d   = in_data;
          state_d = S_LEN;
        end
        S_LEN: begin
          acc_d = acc_sum;
          if (in_data == '0) begin
            state_d = S_DONE;
          end else begin
            cnt_d   = in_data;
            state_d = S_DATA;
          end
        end
        S_DATA: begin
          mem_we_d   = 1'b1;
          mem_addr_d = ptr_q;
          mem_data_d = in_data;
          acc_d      = acc_sum;
          ptr_d      = ptr_q + addr_size'(1);
          cnt_d      = cnt_q - word_size'(1);
          if (cnt_q == word_size'(1)) state_d = S_CKSUM;
        end
        S_CKSUM: begin
          state_d = (acc_sum == '0) ? S_ADDR : S_ERR;
        end
        default: ;
      endcase
    end
  end

  // State and write-port registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q    <= S_ADDR;
      ptr_q      <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// tb_boot_loader: directed frames plus randomized frame streams, checked
// cycle by cycle against a frame-position reference model.
module tb_boot_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready, mem_we, cpu_run, busy, done, error;
  logic [7:0] mem_addr, mem_data;

  boot_loader #(.word_size(8), .addr_size(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .in_valid(in_valid),
    .in_data (in_data),
    .in_ready(in_ready),
    .mem_we  (mem_we),
    .mem_addr(mem_addr),
    .mem_data(mem_data),
    .cpu_run (cpu_run),
    .busy    (busy),
    .done    (done),
    .error   (error)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  bit cmp_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: position within the current frame plus a byte sum.
  int         m_pos = 0, m_base = 0, m_len = 0, m_sum = 0, m_addr = 0;
  bit         m_done = 1'b0, m_err = 1'b0, m_we = 1'b0;
  logic [7:0] m_data = 8'h00;
  logic [7:0] m_mem  [256];
  logic [7:0] dut_mem[256];
  logic [15:0] wlog[$];

  always @(posedge clk) begin
    if (rst) begin
      m_pos = 0; m_done = 0; m_err = 0; m_we = 0; m_addr = 0; m_data = 8'h00;
    end else begin
      m_we = 0;
      if (in_valid && !m_done && !m_err) begin
        if (m_pos == 0) begin
          m_base = int'(in_data); m_sum = int'(in_data); m_pos = 1;
        end else if (m_pos == 1) begin
          m_sum += int'(in_data);
          if (in_data == 8'h00) m_done = 1;
          else begin m_len = int'(in_data); m_pos = 2; end
        end else if (m_pos < m_len + 2) begin
          m_addr = (m_base + m_pos - 2) % 256;
          m_data = in_data;
          m_we   = 1;
          m_mem[m_addr] = in_data;
          m_sum += int'(in_data);
          m_pos++;
        end else begin
          if ((m_sum + int'(in_data)) % 256 == 0) m_pos = 0;
          else m_err = 1;
        end
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      logic [5:0] exp_st;
      exp_st = {!m_done && !m_err, (m_pos != 0) && !m_done && !m_err,
                m_done, m_err, m_done, m_we};
      check("status{rdy,busy,done,err,run,we}",
            {in_ready, busy, done, error, cpu_run, mem_we}, exp_st);
      if (m_we) begin
        check("wr_addr", mem_addr, m_addr[7:0]);
        check("wr_data", mem_data, m_data);
      end
      if (mem_we) begin
        wlog.push_back({mem_addr, mem_data});
        dut_mem[mem_addr] = mem_data;
      end
    end
  end

  task automatic drive(input logic v, input logic [7:0] b);
    in_valid = v;
    in_data  = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    drive(1'b1, b);
    repeat (gap) drive(1'b0, 8'($urandom));
    in_valid = 1'b0;
  endtask

  // Sends n bytes from a packed vector, most significant byte first.
  task automatic send_bytes(input logic [63:0] bytes, input int n, input int gap);
    for (int i = 0; i < n; i++) send(bytes[8*(n-1-i) +: 8], gap);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 8'h00);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic check_flags(input string tag, input logic d, input logic e,
                             input logic run, input logic rdy);
    check({tag, "_done"},  done,     d);
    check({tag, "_error"}, error,    e);
    check({tag, "_run"},   cpu_run,  run);
    check({tag, "_ready"}, in_ready, rdy);
  endtask

  initial begin
    int n0;
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    for (int i = 0; i < 256; i++) begin m_mem[i] = 8'h00; dut_mem[i] = 8'h00; end
    @(posedge clk);
    #1;
    rst    = 1'b0;
    cmp_en = 1'b1;

    // Reset state.
    check_flags("reset", 1'b0, 1'b0, 1'b0, 1'b1);
    check("reset_busy", busy, 1'b0);
    check("reset_we", mem_we, 1'b0);
    check("reset_addr", mem_addr, 8'h00);
    check("reset_data", mem_data, 8'h00);

    // Single frame plus end record.
    wlog.delete();
    send_bytes(64'h80_02_06_01_77_00_00, 7, 0);
    idle(2);
    check("t1_nwr", wlog.size(), 2);
    check("t1_wr0", wlog[0], 16'h8006);
    check("t1_wr1", wlog[1], 16'h8101);
    check_flags("t1", 1'b1, 1'b0, 1'b1, 1'b0);
    check("t1_model_pin", m_mem[128], 8'h06);

    // Bad checksum, then an end record that must be ignored.
    do_reset();
    wlog.delete();
    send_bytes(64'h10_01_AA_00_00_00, 6, 0);
    idle(2);
    check("t2_nwr", wlog.size(), 1);
    check("t2_wr0", wlog[0], 16'h10AA);
    check_flags("t2", 1'b0, 1'b1, 1'b0, 1'b0);

    // Address wrap.
    do_reset();
    wlog.delete();
    send_bytes(64'hFF_02_11_22_CC, 5, 0);
    idle(2);
    check("t3_nwr", wlog.size(), 2);
    check("t3_wr0", wlog[0], 16'hFF11);
    check("t3_wr1", wlog[1], 16'h0022);
    check("t3_busy", busy, 1'b0);
    check_flags("t3", 1'b0, 1'b0, 1'b0, 1'b1);
    check("t3_model_pin", {m_mem[255], m_mem[0]}, 16'h1122);

    // Gapped stream.
    do_reset();
    wlog.delete();
    send_bytes(64'h80_02_06_01_77_00_00, 7, 3);
    idle(2);
    check("t4_nwr", wlog.size(), 2);
    check("t4_wr0", wlog[0], 16'h8006);
    check("t4_wr1", wlog[1], 16'h8101);
    check_flags("t4", 1'b1, 1'b0, 1'b1, 1'b0);

    // Reset mid-frame.
    do_reset();
    wlog.delete();
    send_bytes(64'h80_03_55, 3, 0);
    do_reset();
    check("t5_we_after_rst", mem_we, 1'b0);
    check("t5_nwr_pre", wlog.size(), 1);
    check("t5_wr0", wlog[0], 16'h8055);
    send_bytes(64'h20_01_99_46_00_00, 6, 0);
    idle(2);
    check("t5_nwr", wlog.size(), 2);
    check("t5_wr1", wlog[1], 16'h2099);
    check_flags("t5", 1'b1, 1'b0, 1'b1, 1'b0);

    // Post-done idle with random traffic.
    n0 = wlog.size();
    repeat (20) drive(1'b1, 8'($urandom));
    idle(1);
    check("t6_nwr", wlog.size(), n0);
    check_flags("t6", 1'b1, 1'b0, 1'b1, 1'b0);

    // Randomized frame streams with gaps, bad checksums and stray resets.
    for (int s = 0; s < 6; s++) begin
      do_reset();
      for (int f = 0; f < 6; f++) begin
        logic [7:0] a, l, d, ck;
        int sum;
        a = 8'($urandom);
        l = 8'($urandom_range(1, 8));
        sum = int'(a) + int'(l);
        send(a, $urandom_range(0, 2));
        send(l, $urandom_range(0, 2));
        for (int k = 0; k < int'(l); k++) begin
          d = 8'($urandom);
          sum += int'(d);
          send(d, $urandom_range(0, 2));
          if ($urandom_range(0, 59) == 0) do_reset();
        end
        ck = 8'((256 - (sum % 256)) % 256);
        if ($urandom_range(0, 7) == 0) ck = ck ^ 8'h01;
        send(ck, $urandom_range(0, 2));
      end
      send_bytes(64'h00_00, 2, 0);
      idle(2);
      begin
        int bad;
        bad = 0;
        for (int i = 0; i < 256; i++) if (dut_mem[i] !== m_mem[i]) bad++;
        check("mem_image_mismatches", bad, 0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
